// File: rtl/scope_pkg.sv
// Shared scope constants and types for the capture/readback path.
package scope_pkg;

    localparam int unsigned DEPTH  = 512;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CH_W   = 2;

    localparam logic [CH_W-1:0] CH1    = 2'b00;
    localparam logic [CH_W-1:0] CH2    = 2'b01;
    localparam logic [CH_W-1:0] CH3    = 2'b10;
    localparam logic [CH_W-1:0] CH_INV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_XMIT    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_FIN     = 3'd5
    } dump_state_t;

endpackage

// File: rtl/channel_dump.sv
// Streams one channel's circular capture RAM, oldest sample first, to the UART
// transmitter one byte at a time; pulses dump_fin when the whole trace is out.
module channel_dump #(
    parameter int unsigned DEPTH  = scope_pkg::DEPTH,
    parameter int unsigned ADDR_W = scope_pkg::ADDR_W,
    parameter int unsigned DATA_W = scope_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dump,
    input  logic [scope_pkg::CH_W-1:0]  dump_ch,
    input  logic [ADDR_W-1:0]           trace_end,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_en,
    input  logic [DATA_W-1:0]           ram_rdata1,
    input  logic [DATA_W-1:0]           ram_rdata2,
    input  logic [DATA_W-1:0]           ram_rdata3,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        trmt,
    input  logic                        tx_done,
    output logic                        busy,
    output logic                        dump_fin
);
    import scope_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    dump_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [DATA_W-1:0]   rdata_sel;
    logic                ram_en_q, ram_en_d;
    logic                trmt_q, trmt_d;
    logic                busy_q, busy_d;
    logic                fin_q, fin_d;

    // Read-data mux on the channel frozen at dump start
    always_comb begin
        rdata_sel = ram_rdata3;
        case (ch_q)
            CH1:     rdata_sel = ram_rdata1;
            CH2:     rdata_sel = ram_rdata2;
            default: rdata_sel = ram_rdata3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        tx_data_d = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (dump) begin
                    if (dump_ch == CH_INV) begin
                        state_d = ST_FIN;
                    end else begin
                        ch_d    = dump_ch;
                        addr_d  = trace_end + ONE;
                        cnt_d   = '0;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                tx_data_d = rdata_sel;
                state_d   = ST_XMIT;
            end
            ST_XMIT:  state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (tx_done) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FIN;
                    end else begin
                        addr_d  = addr_q + ONE;
                        cnt_d   = cnt_q + ONE;
                        state_d = ST_READ;
                    end
                end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Strobes are pure functions of the upcoming state, registered below
        ram_en_d = (state_d == ST_READ);
        trmt_d   = (state_d == ST_XMIT);
        busy_d   = (state_d != ST_IDLE);
        fin_d    = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            tx_data_q <= '0;
            ram_en_q  <= 1'b0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            tx_data_q <= tx_data_d;
            ram_en_q  <= ram_en_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
        end
    end

    assign ram_addr = addr_q;
    assign ram_en   = ram_en_q;
    assign tx_data  = tx_data_q;
    assign trmt     = trmt_q;
    assign busy     = busy_q;
    assign dump_fin = fin_q;

endmodule

// File: tb/tb_channel_dump.sv
// Directed bench for channel_dump: RAM and UART models plus a timestamp-based
// expectation model compared against every output on every falling edge.
module tb_channel_dump;

    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dump = 1'b0;
    logic [1:0] dump_ch = 2'b00;
    logic [8:0] trace_end = 9'h000;
    logic [8:0] ram_addr;
    logic       ram_en;
    logic [7:0] rd1 = 8'h00, rd2 = 8'h00, rd3 = 8'h00;
    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done = 1'b0;
    logic       busy;
    logic       dump_fin;

    channel_dump dut (
        .clk(clk), .rst_n(rst_n), .dump(dump), .dump_ch(dump_ch), .trace_end(trace_end),
        .ram_addr(ram_addr), .ram_en(ram_en),
        .ram_rdata1(rd1), .ram_rdata2(rd2), .ram_rdata3(rd3),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .busy(busy), .dump_fin(dump_fin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel RAMs with one-cycle registered read
    logic [7:0] mem1 [DEPTH];
    logic [7:0] mem2 [DEPTH];
    logic [7:0] mem3 [DEPTH];
    always @(posedge clk) if (ram_en) begin
        rd1 <= mem1[ram_addr];
        rd2 <= mem2[ram_addr];
        rd3 <= mem3[ram_addr];
    end

    // Expectation model: edge timestamps of the next trmt / dump_fin
    int         cyc = 0;
    int         trmt_at = -1;
    int         fin_at = -1;
    bit         m_busy = 1'b0;
    bit         awaiting = 1'b0;
    logic [7:0] tx_hold_exp = 8'h00;
    logic [7:0] exp_bytes [$];
    logic [8:0] exp_addrs [$];

    always @(posedge clk) begin : model
        logic [8:0] a;
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0; awaiting = 1'b0; trmt_at = -1; fin_at = -1;
            tx_hold_exp = 8'h00; exp_bytes.delete(); exp_addrs.delete();
        end else begin
            if (awaiting && tx_done) begin
                awaiting = 1'b0;
                if (exp_bytes.size() == 0) fin_at = cyc;
                else trmt_at = cyc + 2;
            end else if (!m_busy && dump) begin
                m_busy = 1'b1;
                if (dump_ch == 2'b11) begin
                    fin_at = cyc;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        a = trace_end + 9'd1 + 9'(i);
                        exp_addrs.push_back(a);
                        case (dump_ch)
                            2'b00:   exp_bytes.push_back(mem1[a]);
                            2'b01:   exp_bytes.push_back(mem2[a]);
                            default: exp_bytes.push_back(mem3[a]);
                        endcase
                    end
                    trmt_at = cyc + 2;
                end
            end
            if (trmt_at >= 0 && cyc == trmt_at && exp_bytes.size() > 0) tx_hold_exp = exp_bytes[0];
            if (trmt_at >= 0 && cyc == trmt_at + 1) awaiting = 1'b1;
            if (fin_at >= 0 && cyc == fin_at + 1) begin m_busy = 1'b0; fin_at = -1; end
        end
    end

    // Observation counters and UART model
    int         n_trmt = 0, rd_cnt = 0, fin_cnt = 0, busy_cnt = 0;
    int         last_trmt_cyc = 0, last_gap = 0;
    bit         wrap_seen = 1'b0;
    logic [8:0] first_addr = 9'h000, last_addr = 9'h000;
    logic [7:0] got_bytes [DEPTH];
    int         tx_delay = 5, tx_hold = 1, cd = 0, hold = 0;

    always @(negedge clk) begin : compare
        logic [7:0] eb;
        logic [8:0] ea;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("ram_en", 32'(ram_en), 32'(trmt_at >= 0 && cyc == trmt_at - 2));
        chk("trmt", 32'(trmt), 32'(trmt_at >= 0 && cyc == trmt_at));
        chk("dump_fin", 32'(dump_fin), 32'(fin_at >= 0 && cyc == fin_at));
        chk("tx_data_hold", 32'(tx_data), 32'(tx_hold_exp));
        if (ram_en) begin
            if (exp_addrs.size() > 0) begin
                ea = exp_addrs.pop_front();
                chk("ram_addr", 32'(ram_addr), 32'(ea));
            end else begin
                chk("reads_left", 32'(exp_addrs.size()), 32'd1);
            end
            if (rd_cnt == 0) first_addr = ram_addr;
            else if (last_addr == 9'h1FF && ram_addr == 9'h000) wrap_seen = 1'b1;
            last_addr = ram_addr;
            rd_cnt++;
        end
        if (trmt) begin
            if (n_trmt < DEPTH) got_bytes[n_trmt] = tx_data;
            if (exp_bytes.size() > 0) begin
                eb = exp_bytes.pop_front();
                chk("byte", 32'(tx_data), 32'(eb));
            end
            if (n_trmt > 0) last_gap = cyc - last_trmt_cyc;
            last_trmt_cyc = cyc;
            n_trmt++;
        end
        if (dump_fin) fin_cnt++;
        if (busy) busy_cnt++;

        if (!rst_n) begin
            cd = 0; hold = 0; tx_done = 1'b0;
        end else begin
            if (hold > 0) begin hold--; if (hold == 0) tx_done = 1'b0; end
            if (cd > 0) begin cd--; if (cd == 0) begin tx_done = 1'b1; hold = tx_hold; end end
            if (trmt) cd = tx_delay;
        end
    end

    task automatic clr();
        n_trmt = 0; rd_cnt = 0; fin_cnt = 0; busy_cnt = 0; wrap_seen = 1'b0;
    endtask

    task automatic pulse_dump(input logic [1:0] ch, input logic [8:0] te);
        @(negedge clk);
        dump = 1'b1; dump_ch = ch; trace_end = te;
        @(negedge clk);
        dump = 1'b0;
    endtask

    task automatic wait_fin(input int budget);
        for (int i = 0; i < budget && fin_cnt < 1; i++) begin @(negedge clk); #1; end
        chk("fin_timeout", 32'(fin_cnt >= 1), 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_trmt(input int target, input int budget);
        for (int i = 0; i < budget && n_trmt < target; i++) begin @(negedge clk); #1; end
        chk("trmt_timeout", 32'(n_trmt >= target), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_trmt"}, 32'(trmt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_dump_fin"}, 32'(dump_fin), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = 8'(i);
            mem2[i] = ~8'(i);
            mem3[i] = 8'(i) ^ 8'h5A;
        end
        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full dump of ch1 from address 0
        clr(); tx_delay = 5; tx_hold = 1;
        pulse_dump(2'b00, 9'h1FF);
        wait_fin(6000);
        chk("t1_count", 32'(n_trmt), 32'd512);
        chk("t1_fins", 32'(fin_cnt), 32'd1);
        chk("t1_first_addr", 32'(first_addr), 32'h000);
        chk("t1_last_addr", 32'(last_addr), 32'h1FF);
        chk("t1_byte0", 32'(got_bytes[0]), 32'h00);
        chk("t1_byte255", 32'(got_bytes[255]), 32'hFF);
        chk("t1_byte256", 32'(got_bytes[256]), 32'h00);
        chk("t1_byte511", 32'(got_bytes[511]), 32'hFF);

        // ch3 with wrap-around
        clr();
        pulse_dump(2'b10, 9'h0A5);
        wait_fin(6000);
        chk("t2_count", 32'(n_trmt), 32'd512);
        chk("t2_first_addr", 32'(first_addr), 32'h0A6);
        chk("t2_last_addr", 32'(last_addr), 32'h0A5);
        chk("t2_wrap", 32'(wrap_seen), 32'd1);
        chk("t2_first_byte", 32'(got_bytes[0]), 32'hFC);
        chk("t2_last_byte", 32'(got_bytes[511]), 32'hFF);

        // Invalid channel
        clr();
        pulse_dump(2'b11, 9'h055);
        wait_fin(20);
        chk("t3_trmt", 32'(n_trmt), 32'd0);
        chk("t3_reads", 32'(rd_cnt), 32'd0);
        chk("t3_busy_cycles", 32'(busy_cnt), 32'd1);
        chk("t3_fins", 32'(fin_cnt), 32'd1);

        // Restart attempt mid-dump with changed channel and trace end
        clr();
        pulse_dump(2'b01, 9'h033);
        wait_trmt(10, 500);
        pulse_dump(2'b10, 9'h100);
        wait_fin(6000);
        chk("t4_count", 32'(n_trmt), 32'd512);
        chk("t4_fins", 32'(fin_cnt), 32'd1);
        chk("t4_first_addr", 32'(first_addr), 32'h034);
        chk("t4_last_addr", 32'(last_addr), 32'h033);
        chk("t4_first_byte", 32'(got_bytes[0]), 32'hCB);
        chk("t4_last_byte", 32'(got_bytes[511]), 32'hCC);

        // Slow transmitter, then tx_done held high for three cycles
        clr(); tx_delay = 100; tx_hold = 1;
        pulse_dump(2'b00, 9'h0FF);
        wait_trmt(4, 1000);
        chk("t5_slow_gap", 32'(last_gap), 32'd103);
        tx_delay = 2; tx_hold = 3;
        wait_trmt(8, 1000);
        chk("t5_held_gap", 32'(last_gap), 32'd5);
        wait_fin(6000);
        chk("t5_count", 32'(n_trmt), 32'd512);
        chk("t5_fins", 32'(fin_cnt), 32'd1);

        // Reset in the middle of a dump, then a fresh dump
        clr(); tx_delay = 5; tx_hold = 1;
        pulse_dump(2'b00, 9'h1FF);
        wait_trmt(37, 1000);
        #1 rst_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_fin", 32'(fin_cnt), 32'd0);
        rst_n = 1'b1;
        clr();
        pulse_dump(2'b00, 9'h010);
        wait_fin(6000);
        chk("t6_count", 32'(n_trmt), 32'd512);
        chk("t6_first_addr", 32'(first_addr), 32'h011);
        chk("t6_first_byte", 32'(got_bytes[0]), 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
